// File: rtl/ed25519_stream_framer.sv
// ed25519_stream_framer: stream <-> wide operand/result framing for the ed25519 core.
// Optional ED25519_STREAM_PERF_EN adds o_perf_cycles (first-in to last-out cycle count).
module ed25519_stream_framer #(
    parameter int DATA_W    = 64,
    parameter int WORD_W    = 256,
    parameter int IN_WORDS  = 3,
    parameter int OUT_WORDS = 2
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_in_valid,
    output logic                          o_in_ready,
    input  logic [DATA_W-1:0]             i_in_data,
    output logic                          o_frame_valid,
    input  logic                          i_frame_ready,
    output logic [IN_WORDS*WORD_W-1:0]    o_frame_data,
    input  logic                          i_res_valid,
    output logic                          o_res_ready,
    input  logic [OUT_WORDS*WORD_W-1:0]   i_res_data,
    output logic                          o_out_valid,
    input  logic                          i_out_ready,
    output logic [DATA_W-1:0]             o_out_data
`ifdef ED25519_STREAM_PERF_EN
    ,
    output logic [31:0]                   o_perf_cycles
`endif
);

    localparam int BEATS     = WORD_W / DATA_W;
    localparam int IN_BEATS  = IN_WORDS * BEATS;
    localparam int OUT_BEATS = OUT_WORDS * BEATS;
    localparam int IN_W      = IN_WORDS * WORD_W;
    localparam int OUT_W     = OUT_WORDS * WORD_W;
    localparam int IN_CW     = $clog2(IN_BEATS + 1);
    localparam int OUT_CW    = $clog2(OUT_BEATS + 1);

    generate
        if (WORD_W % DATA_W != 0) begin : g_bad_word
            $error("WORD_W must be an integer multiple of DATA_W");
        end
        if (IN_WORDS < 1) begin : g_bad_in
            $error("IN_WORDS must be at least 1");
        end
        if (OUT_WORDS < 1) begin : g_bad_out
            $error("OUT_WORDS must be at least 1");
        end
    endgenerate

    typedef enum logic {IN_FILL, IN_HOLD} in_state_t;
    typedef enum logic {OUT_IDLE, OUT_SEND} out_state_t;

    in_state_t          in_state;
    logic [IN_CW-1:0]   in_cnt;
    logic [IN_W-1:0]    frame;

    out_state_t         out_state;
    logic [OUT_CW-1:0]  out_cnt;
    logic [OUT_W-1:0]   shreg;

    logic in_fire;
    logic in_last;
    logic out_fire;
    logic out_last;

    // Readies are registered, so a fire is simply valid && ready.
    assign in_fire  = i_in_valid && o_in_ready;
    assign in_last  = (in_cnt == IN_CW'(IN_BEATS - 1));
    assign out_fire = o_out_valid && i_out_ready;
    assign out_last = (out_cnt == OUT_CW'(OUT_BEATS - 1));

    assign o_frame_data = frame;
    assign o_out_data   = shreg[OUT_W-1 -: DATA_W];

    // Input side: collect beats MSB-first, then hold the frame for the core.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            in_state      <= IN_FILL;
            in_cnt        <= '0;
            frame         <= '0;
            o_in_ready    <= 1'b0;
            o_frame_valid <= 1'b0;
        end else begin
            unique case (in_state)
                IN_FILL: begin
                    o_in_ready <= 1'b1;
                    if (in_fire) begin
                        frame  <= (frame << DATA_W) | IN_W'(i_in_data);
                        in_cnt <= in_cnt + IN_CW'(1);
                        if (in_last) begin
                            in_state      <= IN_HOLD;
                            o_in_ready    <= 1'b0;
                            o_frame_valid <= 1'b1;
                        end
                    end
                end
                IN_HOLD: begin
                    if (i_frame_ready) begin
                        in_state      <= IN_FILL;
                        in_cnt        <= '0;
                        o_in_ready    <= 1'b1;
                        o_frame_valid <= 1'b0;
                    end
                end
            endcase
        end
    end

    // Output side: capture a result frame and stream it out top bits first.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            out_state   <= OUT_IDLE;
            out_cnt     <= '0;
            shreg       <= '0;
            o_res_ready <= 1'b0;
            o_out_valid <= 1'b0;
        end else begin
            unique case (out_state)
                OUT_IDLE: begin
                    o_res_ready <= 1'b1;
                    if (i_res_valid && o_res_ready) begin
                        shreg       <= i_res_data;
                        out_cnt     <= '0;
                        out_state   <= OUT_SEND;
                        o_res_ready <= 1'b0;
                        o_out_valid <= 1'b1;
                    end
                end
                OUT_SEND: begin
                    if (out_fire) begin
                        shreg   <= shreg << DATA_W;
                        out_cnt <= out_cnt + OUT_CW'(1);
                        if (out_last) begin
                            out_cnt     <= '0;
                            out_state   <= OUT_IDLE;
                            o_res_ready <= 1'b1;
                            o_out_valid <= 1'b0;
                        end
                    end
                end
            endcase
        end
    end

`ifdef ED25519_STREAM_PERF_EN
    logic        perf_run;
    logic [31:0] perf;
    logic        first_in;

    assign first_in      = in_fire && (in_cnt == '0);
    assign o_perf_cycles = perf;

    // Latency counter: restart on a frame's first beat, stop on the last result beat.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            perf     <= '0;
            perf_run <= 1'b0;
        end else if (first_in) begin
            perf     <= '0;
            perf_run <= 1'b1;
        end else if (perf_run) begin
            if (perf != 32'hFFFF_FFFF) begin
                perf <= perf + 32'd1;
            end
            if (out_fire && out_last) begin
                perf_run <= 1'b0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ed25519_stream_framer.sv
// tb_ed25519_stream_framer: randomized bench for ed25519_stream_framer.
// Reference model is a list of beats compared against frames and result slices.
module tb_ed25519_stream_framer;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [63:0]  in_data = '0;
    logic         frame_valid;
    logic         frame_ready = 1'b0;
    logic [767:0] frame_data;
    logic         res_valid = 1'b0;
    logic         res_ready;
    logic [511:0] res_data = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [63:0]  out_data;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [63:0] beats [12];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ed25519_stream_framer dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_in_valid    (in_valid),
        .o_in_ready    (in_ready),
        .i_in_data     (in_data),
        .o_frame_valid (frame_valid),
        .i_frame_ready (frame_ready),
        .o_frame_data  (frame_data),
        .i_res_valid   (res_valid),
        .o_res_ready   (res_ready),
        .i_res_data    (res_data),
        .o_out_valid   (out_valid),
        .i_out_ready   (out_ready),
        .o_out_data    (out_data)
    );

`ifdef ED25519_STREAM_PERF_EN
    logic         p_in_valid = 1'b0;
    logic         p_in_ready;
    logic [63:0]  p_in_data = '0;
    logic         p_frame_valid;
    logic         p_frame_ready = 1'b0;
    logic [127:0] p_frame_data;
    logic         p_res_valid = 1'b0;
    logic         p_res_ready;
    logic [127:0] p_res_data = '0;
    logic         p_out_valid;
    logic         p_out_ready = 1'b1;
    logic [63:0]  p_out_data;
    logic [31:0]  p_perf;

    ed25519_stream_framer #(
        .DATA_W(64), .WORD_W(128), .IN_WORDS(1), .OUT_WORDS(1)
    ) pdut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_in_valid    (p_in_valid),
        .o_in_ready    (p_in_ready),
        .i_in_data     (p_in_data),
        .o_frame_valid (p_frame_valid),
        .i_frame_ready (p_frame_ready),
        .o_frame_data  (p_frame_data),
        .i_res_valid   (p_res_valid),
        .o_res_ready   (p_res_ready),
        .i_res_data    (p_res_data),
        .o_out_valid   (p_out_valid),
        .i_out_ready   (p_out_ready),
        .o_out_data    (p_out_data),
        .o_perf_cycles (p_perf)
    );
`endif

    task automatic check(input string tag, input logic [767:0] got,
                         input logic [767:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Expected operand frame: beat 0 lands in the top 64 bits.
    function automatic logic [767:0] model_frame();
        logic [767:0] f;
        f = '0;
        for (int i = 0; i < 12; i++) f[(11 - i) * 64 +: 64] = beats[i];
        return f;
    endfunction

    function automatic logic [511:0] rand_res();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[i * 32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic new_beats();
        for (int i = 0; i < 12; i++) beats[i] = {$urandom, $urandom};
    endtask

    // Offer beats[0..n-1]; a beat is consumed when valid && ready at the next edge.
    task automatic send_beats(input int n, input bit rnd);
        int k = 0;
        int guard = 0;
        while (k < n && guard < 2000) begin
            @(negedge clk);
            guard++;
            in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            in_data = beats[k];
            if (in_valid && in_ready) begin
                k++;
                if (k == 12) check("frame_early", frame_valid, 0);
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        check("in_beats_taken", k, n);
    endtask

    task automatic release_frame();
        frame_ready = 1'b1;
        @(negedge clk);
        frame_ready = 1'b0;
        check("rel_in_ready", in_ready, 1);
        check("rel_frame_valid", frame_valid, 0);
    endtask

    task automatic send_result(input logic [511:0] res, input bit rnd);
        logic [63:0] q[$];
        logic [63:0] pd = '0;
        bit pv = 0;
        bit pr = 0;
        bit stable = 1;
        bit nogap = 1;
        int guard = 0;
        while (!res_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        res_valid = 1'b1;
        res_data = res;
        @(negedge clk);
        res_valid = 1'b0;
        check("res_to_out_valid", out_valid, 1);
        check("res_ready_drop", res_ready, 0);
        guard = 0;
        while (q.size() < 8 && guard < 2000) begin
            if (pv && !pr && (out_valid !== 1'b1 || out_data !== pd)) stable = 0;
            if (!rnd && out_valid !== 1'b1) nogap = 0;
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (out_valid && out_ready) q.push_back(out_data);
            pv = out_valid;
            pr = out_ready;
            pd = out_data;
            @(negedge clk);
            guard++;
        end
        out_ready = 1'b0;
        check("out_beat_count", q.size(), 8);
        check("out_stall_stable", stable, 1);
        if (!rnd) check("out_no_bubble", nogap, 1);
        check("res_ready_after", res_ready, 1);
        check("out_valid_after", out_valid, 0);
        for (int i = 0; i < q.size(); i++) begin
            check("out_beat", q[i], res[(7 - i) * 64 +: 64]);
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_ctrl", {in_ready, frame_valid, res_ready, out_valid}, 0);
        check("rst_frame", frame_data, 0);
        check("rst_out", out_data, 0);
    endtask

    initial begin
        logic [767:0] snap;
        bit ok;

        repeat (2) @(negedge clk);
        check_reset_outputs();
        rst_n = 1'b1;
        @(negedge clk);
        check("boot_in_ready", in_ready, 1);
        check("boot_res_ready", res_ready, 1);

        // Counting pattern, valid held high.
        for (int i = 0; i < 12; i++) beats[i] = 64'(i + 1);
        send_beats(12, 0);
        check("frame_latency", frame_valid, 1);
        check("frame_data", frame_data, model_frame());
        snap = frame_data;
        check("frame_top", snap[767:704], 64'h1);
        check("frame_bot", snap[63:0], 64'hC);

        // Core stalls the frame while a 13th beat is offered.
        in_valid = 1'b1;
        in_data = 64'hDEAD_BEEF_0000_000D;
        ok = 1;
        repeat (10) begin
            @(negedge clk);
            if (in_ready !== 1'b0 || frame_valid !== 1'b1 ||
                frame_data !== snap) ok = 0;
        end
        check("hold_stall", ok, 1);
        frame_ready = 1'b1;
        @(negedge clk);
        frame_ready = 1'b0;
        in_valid = 1'b0;
        check("hold_rel_ready", in_ready, 1);
        check("hold_rel_valid", frame_valid, 0);

        send_result({{64{4'hA}}, {64{4'h5}}}, 0);
        send_result({{64{4'hA}}, {64{4'h5}}}, 1);

        // Both directions busy at once, random stalls on every handshake.
        for (int it = 0; it < 4; it++) begin
            new_beats();
            fork
                begin
                    send_beats(12, 1);
                    check("cc_frame", frame_data, model_frame());
                    repeat ($urandom_range(0, 4)) @(negedge clk);
                    release_frame();
                end
                send_result(rand_res(), 1);
            join
        end

        // Reset in the middle of a frame discards the partial beats.
        new_beats();
        send_beats(5, 1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst2_in_ready", in_ready, 1);
        new_beats();
        send_beats(12, 1);
        check("rst2_frame", frame_data, model_frame());
        release_frame();

`ifdef ED25519_STREAM_PERF_EN
        begin
            int t0;
            int t1;
            int n;
            int guard;
            @(negedge clk);
            p_in_valid = 1'b1;
            p_in_data = 64'h1111;
            t0 = cyc + 1;
            @(negedge clk);
            p_in_data = 64'h2222;
            @(negedge clk);
            p_in_valid = 1'b0;
            check("perf_frame_valid", p_frame_valid, 1);
            check("perf_frame", p_frame_data, {64'h1111, 64'h2222});
            p_frame_ready = 1'b1;
            @(negedge clk);
            p_frame_ready = 1'b0;
            repeat (2) @(negedge clk);
            p_res_valid = 1'b1;
            p_res_data = {64'h3333, 64'h4444};
            @(negedge clk);
            p_res_valid = 1'b0;
            n = 0;
            t1 = 0;
            guard = 0;
            while (n < 2 && guard < 100) begin
                if (p_out_valid && p_out_ready) begin
                    n++;
                    if (n == 2) t1 = cyc + 1;
                end
                @(negedge clk);
                guard++;
            end
            check("perf_beats", n, 2);
            check("perf_count", p_perf, 32'(t1 - t0));
            repeat (5) @(negedge clk);
            check("perf_hold", p_perf, 32'(t1 - t0));
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ed25519_stream_framer.md
Name: ed25519_stream_framer

Overview:
Parametrised I/O framing block between the 64-bit valid/ready stream interface of the ed25519 top level and the wide operand/result buses of the arithmetic core. The input side deserialises IN_WORDS words of WORD_W bits, MSB-first, into one operand frame. The output side serialises an OUT_WORDS-word result frame back onto the stream, MSB-first. It generalises the fixed 3-word-in / 2-word-out, 64-bit protocol to any width and word count, and holds the stream correctly under random handshake stalls on both sides.

Parameters:
DATA_W, 64, stream beat width in bits
WORD_W, 256, operand/result word width; must be an integer multiple of DATA_W
IN_WORDS, 3, words per input frame (scalar, x, y); must be >= 1
OUT_WORDS, 2, words per result frame (x, y); must be >= 1

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
i_in_valid  in  1  input beat valid
o_in_ready  out  1  input beat ready
i_in_data  in  DATA_W  input beat
o_frame_valid  out  1  operand frame valid to core
i_frame_ready  in  1  core accepts frame
o_frame_data  out  IN_WORDS*WORD_W  operand frame; first-received beat occupies the top bits
i_res_valid  in  1  result frame valid from core
o_res_ready  out  1  framer accepts result frame
i_res_data  in  OUT_WORDS*WORD_W  result frame; top bits are sent first
o_out_valid  out  1  output beat valid
i_out_ready  in  1  output beat ready
o_out_data  out  DATA_W  output beat

Behaviour:
- Beat counts: BEATS = WORD_W/DATA_W; IN_BEATS = IN_WORDS*BEATS; OUT_BEATS = OUT_WORDS*BEATS. Counter widths are $clog2 of count+1.
- Reset (async assert, sync release): every output and every register goes to 0, and both FSMs go to their first state. o_in_ready and o_res_ready are registered; each rises at the first i_clk edge after reset release.
- A handshake is valid && ready sampled at the rising edge of i_clk. Ready outputs never depend combinationally on the valid inputs.
- Input FSM IN_FILL -> IN_HOLD -> IN_FILL:
  - IN_FILL: o_in_ready=1. Each handshake shifts the frame register left by DATA_W, loads i_in_data into the LSBs and increments the beat counter.
  - On the IN_BEATS-th handshake: next cycle o_frame_valid=1, o_in_ready=0, state = IN_HOLD. Latency is exactly 1 cycle.
  - IN_HOLD: o_frame_data is stable. When i_frame_ready is sampled high, the next cycle has o_frame_valid=0, o_in_ready=1, counter=0, state = IN_FILL.
  - i_in_valid while o_in_ready=0 is ignored; no data is lost or duplicated.
- Output FSM OUT_IDLE -> OUT_SEND -> OUT_IDLE:
  - OUT_IDLE: o_res_ready=1. On an i_res_valid handshake, the shift register loads i_res_data. Next cycle o_res_ready=0, o_out_valid=1, o_out_data = top DATA_W bits.
  - OUT_SEND: o_out_data and o_out_valid are held while i_out_ready=0. Each out handshake shifts left by DATA_W and increments the counter.
  - After the OUT_BEATS-th out handshake: next cycle o_out_valid=0, o_res_ready=1, state = OUT_IDLE. No bubble is inserted between beats when i_out_ready stays high.
- The two FSMs are independent. A new input frame may fill while a result is being sent.
- Reset mid-frame discards any partial input frame and any partial output. The next frame starts counting from beat 0.
- Elaboration error if WORD_W % DATA_W != 0, IN_WORDS < 1 or OUT_WORDS < 1.

Optional Feature:
ED25519_STREAM_PERF_EN:
- Defined: adds port o_perf_cycles (out, 32). The counter clears on the first input-beat handshake of a frame. It counts every cycle until the last output-beat handshake, then freezes. It saturates at 32'hFFFF_FFFF and resets to 0.
- Undefined: the port and counter are absent, and behaviour is otherwise identical.

Test Plan:
1. Defaults, i_in_valid held 1, 12 beats 64'h1..64'hC.
   -> o_frame_valid rises 1 cycle after the 12th handshake.
   -> o_frame_data[767:704]=64'h1, [63:0]=64'hC.
2. Frame held with i_frame_ready=0 for 10 cycles, i_in_valid held 1.
   -> o_in_ready stays 0 and the 13th beat is not taken.
   -> After i_frame_ready=1 for 1 cycle, o_in_ready=1 on the next cycle.
3. i_res_data = {256'hA...A, 256'h5...5}, i_out_ready held 1.
   -> 8 consecutive beats: four of 64'hAAAA_AAAA_AAAA_AAAA, then four of 64'h5555_5555_5555_5555.
   -> o_res_ready=1 the cycle after the last beat.
4. Same result, i_out_ready random 50%.
   -> o_out_data is stable during every stall.
   -> Exactly 8 handshakes occur, in the order of case 3.
5. Assert i_rst_n=0 after 5 input beats, then release and send 12 fresh beats.
   -> All outputs are 0 during reset.
   -> The frame contains only the new 12 beats.
6. ED25519_STREAM_PERF_EN with WORD_W=128, IN_WORDS=1, OUT_WORDS=1, core result returned 3 cycles after the frame handshake.
   -> 2 input beats and 2 output beats.
   -> o_perf_cycles equals the measured first-in to last-out cycle count and then holds.
